// File: rtl/calc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_arb_pkg
// Description : Shared types and constants for the calculator request
//               arbiter: FSM state encoding, calc opcode encoding and the
//               result value reported on an aborted command.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Opcode encoding understood by the calc core. The arbiter only passes it
    // through; the encoding lives here so requesters and benches agree.
    localparam int c_OP_W = 2;

    typedef enum logic [c_OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    // Result value returned alongside rsp_err when the core gives no answer.
    localparam int unsigned c_ERR_RESULT = 0;

endpackage : calc_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational masked-priority round-robin picker. Requests at
//               or above i_ptr are searched first (lowest index wins); if none
//               exist the unmasked vector is searched, which gives the wrap
//               from NUM_REQ-1 back to 0.
// Ports       : i_req   - request vector
//               i_ptr   - index with highest priority this cycle
//               o_grant - one-hot grant (zero when no request)
//               o_idx   - index of the granted request
//               o_any   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pick;

    always_comb begin
        // Bits [NUM_REQ-1:i_ptr] set.
        w_mask   = ~((NUM_REQ'(1) << i_ptr) - NUM_REQ'(1));
        w_masked = i_req & w_mask;
        w_pick   = (|w_masked) ? w_masked : i_req;
        o_grant  = '0;
        o_idx    = '0;
        // Descending scan so the lowest set bit is the final assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/calc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : calc_req_arbiter
// Description : Shares one multi-cycle calc core among NUM_REQ requesters.
//               Round-robin grant, one command in flight, start/done handshake
//               with the core, result routed back to the issuing requester.
//               Optional watchdog: define CALC_TIMEOUT_EN to abort a command
//               after TIMEOUT_CYCLES in WAIT (result 0, error flag set).
// Ports       : ACLK, ARESET          - clock / synchronous active-high reset
//               req_valid/ready       - per-requester command handshake
//               req_opa/opb/op        - packed per-requester command fields
//               rsp_valid/ready       - per-requester response handshake
//               rsp_result, rsp_err   - shared response data
//               calc_start, calc_op*  - command to the core
//               calc_done/result/err  - completion from the core
//               busy, grant_id        - status
// Revision    : 1.0 - initial release
// ============================================================================
module calc_req_arbiter
    import calc_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int OP_W           = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_opa,
    input  logic [NUM_REQ*DATA_W-1:0]   req_opb,
    input  logic [NUM_REQ*OP_W-1:0]     req_op,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_err,
    output logic                        calc_start,
    output logic [DATA_W-1:0]           calc_opa,
    output logic [DATA_W-1:0]           calc_opb,
    output logic [OP_W-1:0]             calc_op,
    input  logic                        calc_done,
    input  logic [DATA_W-1:0]           calc_result,
    input  logic                        calc_err,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic [DATA_W-1:0]    r_opa;
    logic [DATA_W-1:0]    r_opb;
    logic [OP_W-1:0]      r_op;
    logic [DATA_W-1:0]    r_result;
    logic                 r_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_any;
    logic                 w_rsp_hs;
    logic                 w_timeout;
    logic [c_IDX_W-1:0]   w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_rsp_hs   = (r_state == RESP) && rsp_ready[r_grant_id];
    assign w_ptr_next = (r_grant_id == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + c_IDX_W'(1);

`ifdef CALC_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    // Counter is 0 in the first WAIT cycle, so TIMEOUT_CYCLES-1 marks the
    // last WAIT cycle; RESP follows exactly TIMEOUT_CYCLES cycles after entry.
    assign w_timeout = (r_state == WAIT) && (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wd_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_wd_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        rsp_valid    = '0;
        calc_start   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = w_grant;
                if (w_any) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                calc_start   = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (calc_done || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid[r_grant_id] = 1'b1;
                if (w_rsp_hs) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_opa      <= req_opa[w_idx*DATA_W +: DATA_W];
                        r_opb      <= req_opb[w_idx*DATA_W +: DATA_W];
                        r_op       <= req_op[w_idx*OP_W +: OP_W];
                        r_grant_id <= w_idx;
                    end
                end
                WAIT: begin
                    // A completion coinciding with the timeout takes priority.
                    if (calc_done) begin
                        r_result <= calc_result;
                        r_err    <= calc_err;
                    end else if (w_timeout) begin
                        r_result <= DATA_W'(c_ERR_RESULT);
                        r_err    <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign calc_opa   = r_opa;
    assign calc_opb   = r_opb;
    assign calc_op    = r_op;
    assign rsp_result = r_result;
    assign rsp_err    = r_err;
    assign busy       = (r_state != IDLE);
    assign grant_id   = r_grant_id;

endmodule : calc_req_arbiter
`default_nettype wire

// File: tb/tb_calc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_req_arbiter
// Description : Scoreboard bench for calc_req_arbiter. Stimulus pushes the
//               expected grant order and responses; independent monitors pop
//               and compare on each accept and response handshake. A small
//               behavioural core answers calc_start with a programmable delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_req_arbiter;
    import calc_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 2;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_opa = '0;
    logic [N*DW-1:0] req_opb = '0;
    logic [N*OW-1:0] req_op = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '1;
    logic [DW-1:0]   rsp_result;
    logic            rsp_err;
    logic            calc_start;
    logic [DW-1:0]   calc_opa;
    logic [DW-1:0]   calc_opb;
    logic [OW-1:0]   calc_op;
    logic            calc_done;
    logic [DW-1:0]   calc_result;
    logic            calc_err;
    logic            busy;
    logic [1:0]      grant_id;

    // Core model outputs and a separate injector for stale completions.
    logic            core_done = 1'b0;
    logic [DW-1:0]   core_result = '0;
    logic            core_err = 1'b0;
    logic            inj_done = 1'b0;
    logic [DW-1:0]   inj_result = '0;
    logic            core_en = 1'b1;
    int              core_lat = 1;

    assign calc_done   = core_done | inj_done;
    assign calc_result = inj_done ? inj_result : core_result;
    assign calc_err    = core_err;

    always #5 ACLK = ~ACLK;

    calc_req_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (DW),
        .OP_W           (OW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opa     (req_opa),
        .req_opb     (req_opb),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .calc_start  (calc_start),
        .calc_opa    (calc_opa),
        .calc_opb    (calc_opb),
        .calc_op     (calc_op),
        .calc_done   (calc_done),
        .calc_result (calc_result),
        .calc_err    (calc_err),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   exp_grant_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_start = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // ------------------------------------------------------------------ core
    initial begin : core_model
        logic [DW-1:0] a, b;
        logic [OW-1:0] op;
        forever begin
            @(negedge ACLK);
            if (calc_start && core_en && !ARESET) begin
                a  = calc_opa;
                b  = calc_opb;
                op = calc_op;
                @(posedge ACLK);
                repeat (core_lat - 1) @(posedge ACLK);
                #1;
                core_err = 1'b0;
                case (op)
                    OP_ADD:  core_result = a + b;
                    OP_SUB:  core_result = a - b;
                    OP_MUL:  core_result = a * b;
                    default: begin
                        if (b == 0) begin
                            core_result = '0;
                            core_err    = 1'b1;
                        end else begin
                            core_result = a / b;
                        end
                    end
                endcase
                core_done = 1'b1;
                @(posedge ACLK);
                #1;
                core_done = 1'b0;
                core_err  = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------- monitors
    always @(negedge ACLK) begin
        if (!ARESET && calc_start) n_start++;
    end

    always @(negedge ACLK) begin : grant_mon
        int id;
        if (!ARESET && (req_ready & req_valid) != '0) begin
            chk("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
            id = onehot_idx(req_ready);
            if (exp_grant_q.size() == 0) begin
                chk("unexpected_grant", 64'(id), 64'hFFFF);
            end else begin
                chk("grant_order", 64'(id), 64'(exp_grant_q.pop_front()));
            end
        end
    end

    always @(negedge ACLK) begin : rsp_mon
        exp_t e;
        if (!ARESET && rsp_valid != '0) begin
            if ($countones(rsp_valid) != 1) chk("rsp_valid_onehot", 64'(rsp_valid), 64'd0);
            if ((rsp_valid & rsp_ready) != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_owner",  64'(onehot_idx(rsp_valid)), 64'(e.id));
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                    chk("rsp_err",    64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        req_opa[i*DW +: DW] = a;
        req_opb[i*DW +: DW] = b;
        req_op[i*OW +: OW]  = op;
        req_valid[i]        = 1'b1;
    endtask

    task automatic expect_rsp(input int id, input logic [31:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Waits for an accept, returns its index, leaves time at #1 after the edge.
    task automatic wait_accept(output int id);
        bit got = 0;
        id = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge ACLK);
            if ((req_ready & req_valid) != '0) begin
                id  = onehot_idx(req_ready & req_valid);
                got = 1;
            end
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge ACLK);
            if (!busy && rsp_valid == '0) got = 1;
        end
        if (!got) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    initial begin : stim
        int id;
        int n;
        bit got;

        // Reset values.
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_start_busy", 64'({calc_start, busy, rsp_err}), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_calc_ops", 64'({calc_opa, calc_opb} | 64'(calc_op)), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        // All four continuously valid: 0,1,2,3,0,1.
        core_lat = 1;
        set_req(0, 32'd5,   32'd7, OP_ADD);
        set_req(1, 32'd20,  32'd3, OP_SUB);
        set_req(2, 32'd6,   32'd7, OP_MUL);
        set_req(3, 32'd100, 32'd7, OP_DIV);
        exp_grant_q = '{0, 1, 2, 3, 0, 1};
        expect_rsp(0, 32'd12, 1'b0);
        expect_rsp(1, 32'd17, 1'b0);
        expect_rsp(2, 32'd42, 1'b0);
        expect_rsp(3, 32'd14, 1'b0);
        expect_rsp(0, 32'd12, 1'b0);
        expect_rsp(1, 32'd17, 1'b0);
        for (int k = 0; k < 6; k++) wait_accept(id);
        req_valid = '0;
        wait_idle();

        // Single request, 3-cycle core.
        core_lat = 3;
        set_req(0, 32'd5, 32'd7, OP_ADD);
        exp_grant_q.push_back(0);
        expect_rsp(0, 32'h0000000C, 1'b0);
        wait_accept(id);
        req_valid[0] = 1'b0;
        wait_idle();

        // Response back-pressure on requester 2; requester 0 waits meanwhile.
        core_lat  = 1;
        rsp_ready = 4'b1011;
        set_req(2, 32'd9, 32'd4, OP_SUB);
        exp_grant_q.push_back(2);
        expect_rsp(2, 32'd5, 1'b0);
        wait_accept(id);
        req_valid[2] = 1'b0;
        set_req(0, 32'd1, 32'd1, OP_ADD);
        exp_grant_q.push_back(0);
        expect_rsp(0, 32'd2, 1'b0);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge ACLK);
            if (rsp_valid[2]) got = 1;
        end
        chk("hold_rsp_seen", 64'(got), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'b0100);
            chk("hold_rsp_result", 64'(rsp_result), 64'd5);
            chk("hold_no_start", 64'({calc_start, req_ready}), 64'd0);
        end
        @(posedge ACLK);
        #1;
        rsp_ready = '1;
        wait_accept(id);
        req_valid[0] = 1'b0;
        wait_idle();

        // Divide by zero reports an error; the next command is normal.
        set_req(3, 32'd50, 32'd0, OP_DIV);
        exp_grant_q.push_back(3);
        expect_rsp(3, 32'd0, 1'b1);
        wait_accept(id);
        req_valid[3] = 1'b0;
        wait_idle();
        set_req(1, 32'd8, 32'd9, OP_ADD);
        exp_grant_q.push_back(1);
        expect_rsp(1, 32'd17, 1'b0);
        wait_accept(id);
        req_valid[1] = 1'b0;
        wait_idle();

        // Reset while waiting on the core, then a stale completion.
        core_en = 1'b0;
        set_req(3, 32'd1, 32'd2, OP_ADD);
        exp_grant_q.push_back(3);
        wait_accept(id);
        req_valid[3] = 1'b0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_busy", 64'({busy, calc_start, rsp_err}), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
        chk("mid_rst_calc_opa", 64'(calc_opa), 64'd0);
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        inj_result = 32'hDEAD_BEEF;
        inj_done   = 1'b1;
        @(posedge ACLK);
        #1;
        inj_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("stale_done_ignored", 64'({busy, rsp_valid}), 64'd0);
        end
        chk("stale_rsp_result", 64'(rsp_result), 64'd0);
        core_en = 1'b1;
        @(posedge ACLK);
        #1;

        // Pointer back at 0: requester 1 beats requester 3.
        set_req(1, 32'd2, 32'd3, OP_ADD);
        set_req(3, 32'd3, 32'd4, OP_MUL);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(3);
        expect_rsp(1, 32'd5, 1'b0);
        expect_rsp(3, 32'd12, 1'b0);
        wait_accept(id);
        req_valid[id] = 1'b0;
        wait_accept(id);
        req_valid[id] = 1'b0;
        wait_idle();

`ifdef CALC_TIMEOUT_EN
        // Core never answers: watchdog aborts 16 cycles after WAIT entry.
        core_en = 1'b0;
        set_req(0, 32'd1, 32'd1, OP_ADD);
        exp_grant_q.push_back(0);
        expect_rsp(0, 32'd0, 1'b1);
        wait_accept(id);
        req_valid[0] = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge ACLK);
            if (calc_start) got = 1;
        end
        n   = 0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge ACLK);
            n++;
            if (rsp_valid != '0) got = 1;
        end
        chk("timeout_latency", 64'(n), 64'd17);
        wait_idle();
        core_en = 1'b1;
        n_start = n_start - 1;
`endif

        // Drain.
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        chk("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("grant_queue_empty", 64'(exp_grant_q.size()), 64'd0);
        chk("calc_start_count", 64'(n_start), 64'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute safety net.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_calc_req_arbiter
`default_nettype wire
